// File: rtl/icache.sv
//==============================================================================
// Module      : icache
// Description : Direct-mapped instruction cache with one-word lines and a
//               single outstanding line fill. The fetch unit holds its request
//               until instr_valid. A miss issues a fill to the memory
//               controller and returns the fill word one cycle after
//               mem_success. jump_wrong aborts any pending fetch.
//               Optional feature macro: ICACHE_FLUSH_EN adds a flush input
//               that invalidates every line and aborts like jump_wrong.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module icache #(
    parameter int INDEX_BITS = 5
) (
    input  logic        clk,
    input  logic        rst,
`ifdef ICACHE_FLUSH_EN
    input  logic        flush,
`endif
    input  logic        rdy,
    input  logic        jump_wrong,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic        mem_read_signal,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_instr,
    input  logic        mem_success
);

    localparam int c_LINES = 1 << INDEX_BITS;
    localparam int c_TAG_W = 30 - INDEX_BITS;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [c_LINES-1:0]     r_valid;
    logic [c_TAG_W-1:0]     r_tag  [c_LINES];
    logic [31:0]            r_data [c_LINES];

    logic                   r_instr_valid;
    logic [31:0]            r_instr;
    logic                   r_mem_read;
    logic [31:0]            r_mem_addr;

    logic                   w_abort;
    logic [INDEX_BITS-1:0]  w_idx;
    logic [c_TAG_W-1:0]     w_tag;
    logic                   w_hit;
    logic                   w_accept;
    logic                   w_fill;
    logic [INDEX_BITS-1:0]  w_fill_idx;
    logic [c_TAG_W-1:0]     w_fill_tag;
    logic                   w_unused_ok;

`ifdef ICACHE_FLUSH_EN
    // Flush behaves like a mispredict abort and additionally wipes the valid bits
    assign w_abort = jump_wrong | flush;
`else
    assign w_abort = jump_wrong;
`endif

    // Lookup fields; the byte offset of the fetch address is not used
    assign w_idx       = fetch_pc[INDEX_BITS+1:2];
    assign w_tag       = fetch_pc[31:INDEX_BITS+2];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_unused_ok = &{1'b0, fetch_pc[1:0]};

    // mem_addr doubles as the latched miss pc, so the fill line comes from it
    assign w_fill_idx = r_mem_addr[INDEX_BITS+1:2];
    assign w_fill_tag = r_mem_addr[31:INDEX_BITS+2];

    // A request is not taken in the cycle its predecessor's response is shown
    assign w_accept = rdy && !w_abort && (r_state == IDLE) && fetch_valid && !r_instr_valid;
    assign w_fill   = rdy && !w_abort && (r_state == MISS) && mem_success;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: abort wins over a stall, a stall freezes the state
    always_comb begin
        w_state_next = r_state;
        if (w_abort) begin
            w_state_next = IDLE;
        end else if (rdy) begin
            case (r_state)
                IDLE:    if (w_accept && !w_hit) w_state_next = MISS;
                MISS:    if (mem_success)        w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Response and fill-request registers plus the line valid bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid       <= '0;
            r_instr_valid <= 1'b0;
            r_instr       <= 32'd0;
            r_mem_read    <= 1'b0;
            r_mem_addr    <= 32'd0;
        end else begin
            if (w_abort) begin
                r_instr_valid <= 1'b0;
                r_mem_read    <= 1'b0;
            end else if (rdy) begin
                r_instr_valid <= (w_accept && w_hit) || w_fill;
                if (w_accept && w_hit) begin
                    r_instr <= r_data[w_idx];
                end
                if (w_accept && !w_hit) begin
                    r_mem_read <= 1'b1;
                    r_mem_addr <= {fetch_pc[31:2], 2'b00};
                end
                if (w_fill) begin
                    r_instr    <= mem_instr;
                    r_mem_read <= 1'b0;
                end
            end
`ifdef ICACHE_FLUSH_EN
            if (flush) begin
                r_valid <= '0;
            end else if (w_fill) begin
                r_valid[w_fill_idx] <= 1'b1;
            end
`else
            if (w_fill) begin
                r_valid[w_fill_idx] <= 1'b1;
            end
`endif
        end
    end

    // Tag and data arrays are written only by a completed fill; no reset needed
    always_ff @(posedge clk) begin
        if (w_fill && !rst) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= mem_instr;
        end
    end

    assign instr_valid     = r_instr_valid;
    assign instr           = r_instr;
    assign mem_read_signal = r_mem_read;
    assign mem_addr        = r_mem_addr;

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
//==============================================================================
// Module      : tb_icache
// Description : Self-checking bench for icache against a word-address cache
//               model (INDEX_BITS = 5).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_icache;

    localparam int IB    = 5;
    localparam int LINES = 1 << IB;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        jump_wrong;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic        mem_read_signal;
    logic [31:0] mem_addr;
    logic [31:0] mem_instr;
    logic        mem_success;
`ifdef ICACHE_FLUSH_EN
    logic        flush;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: each line remembers the full word address it holds
    bit          mdl_valid [LINES];
    logic [29:0] mdl_waddr [LINES];
    logic [31:0] mdl_data  [LINES];
    logic [31:0] last_instr;

    icache #(.INDEX_BITS(IB)) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef ICACHE_FLUSH_EN
        .flush          (flush),
`endif
        .rdy            (rdy),
        .jump_wrong     (jump_wrong),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .mem_read_signal(mem_read_signal),
        .mem_addr       (mem_addr),
        .mem_instr      (mem_instr),
        .mem_success    (mem_success)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) mdl_valid[i] = 1'b0;
    endtask

    // One complete fetch; on a miss the memory answers after lat extra cycles
    task automatic do_fetch(input logic [31:0] pc, input int lat,
                            input logic [31:0] data, input bit abort);
        int idx;
        bit hit;
        logic [31:0] exp_addr;
        idx      = (pc >> 2) % LINES;
        hit      = mdl_valid[idx] && (mdl_waddr[idx] == pc[31:2]);
        exp_addr = pc & 32'hFFFF_FFFC;
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        tick();
        if (hit) begin
            total++;
            if (instr_valid !== 1'b1 || instr !== mdl_data[idx] || mem_read_signal !== 1'b0) begin
                bad++;
                $display("FAIL hit pc=%h: got v=%b instr=%h rd=%b, want v=1 instr=%h rd=0",
                         pc, instr_valid, instr, mem_read_signal, mdl_data[idx]);
            end
            last_instr  = mdl_data[idx];
            fetch_valid = 1'b0;
        end else begin
            total++;
            if (mem_read_signal !== 1'b1 || mem_addr !== exp_addr || instr_valid !== 1'b0) begin
                bad++;
                $display("FAIL miss_req pc=%h: got rd=%b addr=%h v=%b, want rd=1 addr=%h v=0",
                         pc, mem_read_signal, mem_addr, instr_valid, exp_addr);
            end
            for (int i = 0; i < lat; i++) begin
                tick();
                total++;
                if (mem_read_signal !== 1'b1 || mem_addr !== exp_addr || instr_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL miss_hold pc=%h: got rd=%b addr=%h v=%b, want rd=1 addr=%h v=0",
                             pc, mem_read_signal, mem_addr, instr_valid, exp_addr);
                end
            end
            mem_success = 1'b1;
            mem_instr   = data;
            jump_wrong  = abort;
            tick();
            mem_success = 1'b0;
            jump_wrong  = 1'b0;
            fetch_valid = 1'b0;
            if (abort) begin
                total++;
                if (instr_valid !== 1'b0 || mem_read_signal !== 1'b0) begin
                    bad++;
                    $display("FAIL abort pc=%h: got v=%b rd=%b, want v=0 rd=0",
                             pc, instr_valid, mem_read_signal);
                end
            end else begin
                total++;
                if (instr_valid !== 1'b1 || instr !== data || mem_read_signal !== 1'b0) begin
                    bad++;
                    $display("FAIL fill pc=%h: got v=%b instr=%h rd=%b, want v=1 instr=%h rd=0",
                             pc, instr_valid, instr, mem_read_signal, data);
                end
                mdl_valid[idx] = 1'b1;
                mdl_waddr[idx] = pc[31:2];
                mdl_data[idx]  = data;
                last_instr     = data;
            end
        end
        tick();
        total++;
        if (instr_valid !== 1'b0 || instr !== last_instr || mem_read_signal !== 1'b0) begin
            bad++;
            $display("FAIL after pc=%h: got v=%b instr=%h rd=%b, want v=0 instr=%h rd=0",
                     pc, instr_valid, instr, mem_read_signal, last_instr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; jump_wrong = 1'b1; fetch_valid = 1'b1;
        fetch_pc = 32'h0; mem_instr = 32'h0; mem_success = 1'b0;
`ifdef ICACHE_FLUSH_EN
        flush = 1'b0;
`endif
        tick(); tick();
        total++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || mem_read_signal !== 1'b0 || mem_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset: got v=%b instr=%h rd=%b addr=%h, want all zero",
                     instr_valid, instr, mem_read_signal, mem_addr);
        end
        rst = 1'b0; jump_wrong = 1'b0; fetch_valid = 1'b0;
        model_clear();
        last_instr = 32'h0;
        tick();
    endtask

    task automatic test_directed();
        do_fetch(32'h0000_1000, 2, 32'h0010_0093, 1'b0);   // cold miss
        do_fetch(32'h0000_1000, 0, 32'hDEAD_BEEF, 1'b0);   // hit
        do_fetch(32'h0000_1080, 1, 32'h1234_5678, 1'b0);   // conflict
        do_fetch(32'h0000_1000, 0, 32'h0010_0093, 1'b0);   // evicted, misses again
    endtask

    task automatic test_back_to_back();
        logic [3:0] pat;
        pat = 4'b0101;
        fetch_valid = 1'b1;
        fetch_pc    = 32'h0000_1000;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (instr_valid !== pat[i] || mem_read_signal !== 1'b0) begin
                bad++;
                $display("FAIL b2b cyc=%0d: got v=%b rd=%b, want v=%b rd=0",
                         i, instr_valid, mem_read_signal, pat[i]);
            end
        end
        fetch_valid = 1'b0;
        tick();
    endtask

    task automatic test_idle_success();
        mem_success = 1'b1;
        mem_instr   = 32'hFFFF_0000;
        tick();
        mem_success = 1'b0;
        tick();
        total++;
        if (instr_valid !== 1'b0 || mem_read_signal !== 1'b0 || instr !== last_instr) begin
            bad++;
            $display("FAIL idle_success: got v=%b rd=%b instr=%h, want v=0 rd=0 instr=%h",
                     instr_valid, mem_read_signal, instr, last_instr);
        end
    endtask

    task automatic test_abort();
        do_fetch(32'h0000_2004, 1, 32'hAAAA_5555, 1'b1);   // abort with coinciding fill
        do_fetch(32'h0000_2004, 0, 32'h5555_AAAA, 1'b0);   // line must still be empty
        // jump_wrong alone, mid-miss
        fetch_valid = 1'b1; fetch_pc = 32'h0000_3008;
        tick();
        jump_wrong = 1'b1; fetch_valid = 1'b0;
        tick();
        jump_wrong = 1'b0;
        total++;
        if (mem_read_signal !== 1'b0 || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL jump_miss: got rd=%b v=%b, want rd=0 v=0", mem_read_signal, instr_valid);
        end
        tick();
    endtask

    task automatic test_stall();
        fetch_valid = 1'b1; fetch_pc = 32'h0000_400C;
        tick();
        rdy = 1'b0; mem_success = 1'b1; mem_instr = 32'h0BAD_F00D;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (mem_read_signal !== 1'b1 || mem_addr !== 32'h0000_400C || instr_valid !== 1'b0) begin
                bad++;
                $display("FAIL stall cyc=%0d: got rd=%b addr=%h v=%b, want rd=1 addr=0000400c v=0",
                         i, mem_read_signal, mem_addr, instr_valid);
            end
        end
        rdy = 1'b1;
        tick();
        mem_success = 1'b0; fetch_valid = 1'b0;
        total++;
        if (instr_valid !== 1'b1 || instr !== 32'h0BAD_F00D || mem_read_signal !== 1'b0) begin
            bad++;
            $display("FAIL stall_resume: got v=%b instr=%h rd=%b, want v=1 instr=0badf00d rd=0",
                     instr_valid, instr, mem_read_signal);
        end
        mdl_valid[3]  = 1'b1;
        mdl_waddr[3]  = 30'h0000_1003;
        mdl_data[3]   = 32'h0BAD_F00D;
        last_instr    = 32'h0BAD_F00D;
        tick();
        do_fetch(32'h0000_400C, 0, 32'h0, 1'b0);           // now a hit
    endtask

    task automatic test_reset_miss();
        fetch_valid = 1'b1; fetch_pc = 32'h0000_5010;
        tick();
        rst = 1'b1; mem_success = 1'b1; mem_instr = 32'h7777_7777;
        tick();
        rst = 1'b0; mem_success = 1'b0; fetch_valid = 1'b0;
        total++;
        if (instr_valid !== 1'b0 || mem_read_signal !== 1'b0 || instr !== 32'h0 || mem_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_miss: got v=%b rd=%b instr=%h addr=%h, want all zero",
                     instr_valid, mem_read_signal, instr, mem_addr);
        end
        model_clear();
        last_instr = 32'h0;
        tick();
        do_fetch(32'h0000_400C, 0, 32'h1111_2222, 1'b0);   // invalidated by reset
    endtask

`ifdef ICACHE_FLUSH_EN
    task automatic test_flush();
        do_fetch(32'h0000_1000, 0, 32'h0010_0093, 1'b0);
        fetch_valid = 1'b1; fetch_pc = 32'h0000_1000; flush = 1'b1;
        tick();
        flush = 1'b0; fetch_valid = 1'b0;
        total++;
        if (instr_valid !== 1'b0 || mem_read_signal !== 1'b0) begin
            bad++;
            $display("FAIL flush_fetch: got v=%b rd=%b, want v=0 rd=0", instr_valid, mem_read_signal);
        end
        model_clear();
        tick();
        do_fetch(32'h0000_1000, 1, 32'h0010_0093, 1'b0);   // misses after flush
        fetch_valid = 1'b1; fetch_pc = 32'h0000_6000;
        tick();
        flush = 1'b1; fetch_valid = 1'b0;
        tick();
        flush = 1'b0;
        total++;
        if (instr_valid !== 1'b0 || mem_read_signal !== 1'b0) begin
            bad++;
            $display("FAIL flush_miss: got v=%b rd=%b, want v=0 rd=0", instr_valid, mem_read_signal);
        end
        model_clear();
        tick();
    endtask
`endif

    task automatic test_random();
        logic [31:0] pc;
        for (int n = 0; n < 200; n++) begin
            pc = ($urandom_range(0, 2) << (IB + 2)) | ($urandom_range(0, 3) << 2)
                 | $urandom_range(0, 3) | 32'h0008_0000;
            do_fetch(pc, $urandom_range(0, 3), $urandom, ($urandom_range(0, 7) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_idle_success();
        test_abort();
        test_stall();
        test_reset_miss();
`ifdef ICACHE_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL take parameter INDEX_BITS, default 5, as log2 of the number of direct-mapped one-word lines (32 lines).
REQ-002 The block SHALL have input clk, 1 bit, the system clock.
REQ-003 The block SHALL have input rst, 1 bit, a synchronous, active-high reset.
REQ-004 The block SHALL have input rdy, 1 bit; when it is low, all state and outputs hold.
REQ-005 The block SHALL have input jump_wrong, 1 bit, which aborts the pending fetch.
REQ-006 The block SHALL have input fetch_valid, 1 bit, the fetch unit's request strobe, held until instr_valid.
REQ-007 The block SHALL have input fetch_pc, 32 bits, the fetch address.
REQ-008 The block SHALL have output instr_valid, 1 bit, a one-cycle pulse meaning instr is valid.
REQ-009 The block SHALL have output instr, 32 bits, the returned instruction word.
REQ-010 The block SHALL have output mem_read_signal, 1 bit, the line-fill request to the memory controller.
REQ-011 The block SHALL have output mem_addr, 32 bits, the fill address.
REQ-012 The block SHALL have input mem_instr, 32 bits, the fill data from the memory controller.
REQ-013 The block SHALL have input mem_success, 1 bit, the fill-complete pulse.
REQ-014 When ICACHE_FLUSH_EN is defined, the block SHALL have input flush, 1 bit, which invalidates all lines.

Function
REQ-015 Address fields SHALL be: index = fetch_pc[INDEX_BITS+1:2]; tag = fetch_pc[31:INDEX_BITS+2]; fetch_pc[1:0] is ignored.
REQ-016 Each line SHALL hold a valid bit, a tag and a 32-bit data word.
REQ-017 The block SHALL have two states, IDLE and MISS.
REQ-018 In IDLE, with fetch_valid=1 and a hit (valid and tag equal), the block SHALL, next cycle, set instr_valid=1, set instr to the line data, and stay in IDLE.
REQ-019 In IDLE, with fetch_valid=1 and a miss, the block SHALL, next cycle, set mem_read_signal=1, set mem_addr={fetch_pc[31:2],2'b00}, latch the pc, and go to MISS.
REQ-020 In MISS, the block SHALL hold mem_read_signal and mem_addr stable until mem_success=1.
REQ-021 On mem_success=1 in MISS, the block SHALL write the line (valid=1, latched tag, mem_instr); next cycle it SHALL set instr_valid=1, instr=mem_instr, mem_read_signal=0, and return to IDLE.
REQ-022 Hit latency SHALL be 1 cycle; miss latency SHALL be the memory latency plus 1 cycle.
REQ-023 instr_valid SHALL be high for exactly one cycle per accepted request.
REQ-024 In the cycle where instr_valid=1, the block SHALL NOT accept a new request; the next acceptance is the following cycle.
REQ-025 A jump_wrong=1 in any state SHALL, next cycle, force IDLE with mem_read_signal=0 and instr_valid=0.
REQ-026 If jump_wrong and mem_success coincide, the fill data SHALL be discarded and the line left unchanged.
REQ-027 When mem_success=1 occurs in IDLE, the block SHALL ignore it.
REQ-028 Asserting rdy=0 mid-miss SHALL freeze the state; the fill resumes when rdy=1.
REQ-029 When instr_valid=0, instr SHALL hold its last value.

Reset
REQ-030 On rst=1 at a clk edge, the block SHALL go to IDLE and clear every line valid bit.
REQ-031 On reset, the outputs SHALL be instr_valid=0, instr=0, mem_read_signal=0, mem_addr=0; tag and data arrays need not be reset.
REQ-032 Reset SHALL have priority over jump_wrong, and jump_wrong over rdy.
REQ-033 A reset during MISS SHALL drop the fill, with no instr_valid pulse.

Configuration
REQ-034 With ICACHE_FLUSH_EN defined, flush=1 in IDLE SHALL clear all valid bits next cycle.
REQ-035 With ICACHE_FLUSH_EN defined, flush=1 in MISS SHALL clear all valid bits and abort as for jump_wrong.
REQ-036 With ICACHE_FLUSH_EN defined, a fetch_valid coinciding with flush SHALL NOT be accepted.
REQ-037 Without ICACHE_FLUSH_EN, the flush port and its logic SHALL be absent, and lines are invalidated only by reset.

Verification
REQ-038 Cold miss: after reset, fetch 0x0000_1000 -> next cycle mem_read_signal=1, mem_addr=0x0000_1000; mem_success with 0x0010_0093 -> one cycle later instr_valid=1, instr=0x0010_0093.
REQ-039 Hit: refetch 0x0000_1000 -> instr_valid=1 after 1 cycle, instr=0x0010_0093, mem_read_signal stays 0.
REQ-040 Conflict: fetch 0x0000_1080 (same index, tag differs, INDEX_BITS=5) -> miss; then 0x0000_1000 misses again.
REQ-041 Abort: jump_wrong in MISS together with mem_success -> no instr_valid, mem_read_signal=0 next cycle, line remains invalid.
REQ-042 Stall: rdy=0 for 3 cycles during MISS -> mem_addr stable; the fill completes after rdy=1.
REQ-043 Flush (ICACHE_FLUSH_EN): flush after a fill of 0x0000_1000, then fetch 0x0000_1000 -> miss.
